// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: FWFT word FIFO with overrun/error statistics,
// fill-level threshold flag and an idle-timeout flag for servicing partial packets.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_tick,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   level,
  input  logic [ADDR_WIDTH:0]   rx_thresh,
  output logic                  thresh_hit,
  input  logic [23:0]           timeout_cycles,
  output logic                  rx_timeout,
  output logic                  overrun,
  output logic [CNT_WIDTH-1:0]  parity_err_cnt,
  output logic [CNT_WIDTH-1:0]  frame_err_cnt,
  input  logic                  clr_status
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   FULL_LVL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LVL_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [23:0]           idle_cnt;
  logic                  do_rd;
  logic                  do_wr;
  logic                  idle_clr;
  logic                  drop;

  assign empty      = (count == '0);
  assign full       = (count == FULL_LVL);
  assign level      = count;
  assign rd_data    = empty ? '0 : mem[rd_ptr];
  assign thresh_hit = (rx_thresh != '0) && (count >= rx_thresh);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
  assign do_rd    = rd_en && !empty;
  assign do_wr    = wr_tick && (!full || do_rd);
  assign drop     = wr_tick && full && !rd_en;
  assign idle_clr = empty || do_wr || do_rd || (timeout_cycles == '0);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      case ({do_wr, do_rd})
        2'b10:   count <= count + LVL_ONE;
        2'b01:   count <= count - LVL_ONE;
        default: count <= count;
      endcase
    end
  end

  // Dropped words still count toward the error statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun        <= 1'b0;
      parity_err_cnt <= '0;
      frame_err_cnt  <= '0;
    end else if (clr_status) begin
      overrun        <= 1'b0;
      parity_err_cnt <= '0;
      frame_err_cnt  <= '0;
    end else begin
      if (drop) overrun <= 1'b1;
      if (wr_tick && wr_data[DATA_WIDTH-1] && (parity_err_cnt != CNT_MAX))
        parity_err_cnt <= parity_err_cnt + CNT_ONE;
      if (wr_tick && wr_data[DATA_WIDTH-2] && (frame_err_cnt != CNT_MAX))
        frame_err_cnt <= frame_err_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt   <= '0;
      rx_timeout <= 1'b0;
    end else begin
      if (idle_clr) idle_cnt <= '0;
      else if (idle_cnt < timeout_cycles) idle_cnt <= idle_cnt + 24'd1;

      if (clr_status || do_rd || do_wr) rx_timeout <= 1'b0;
      else if (!idle_clr && (idle_cnt < timeout_cycles) && (idle_cnt + 24'd1 == timeout_cycles))
        rx_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model checked every cycle plus directed
// scenarios with hand-computed literal expectations.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_tick = 1'b0;
  logic [9:0]  wr_data = '0;
  logic        rd_en = 1'b0;
  logic [9:0]  rd_data;
  logic        empty, full;
  logic [4:0]  level;
  logic [4:0]  rx_thresh = '0;
  logic        thresh_hit;
  logic [23:0] timeout_cycles = '0;
  logic        rx_timeout, overrun;
  logic [7:0]  parity_err_cnt, frame_err_cnt;
  logic        clr_status = 1'b0;
  logic        run = 1'b0;

  int total = 0;
  int bad = 0;

  uart_rx_fifo dut (
    .clk(clk), .reset(reset), .wr_tick(wr_tick), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .level(level), .rx_thresh(rx_thresh),
    .thresh_hit(thresh_hit), .timeout_cycles(timeout_cycles), .rx_timeout(rx_timeout),
    .overrun(overrun), .parity_err_cnt(parity_err_cnt), .frame_err_cnt(frame_err_cnt),
    .clr_status(clr_status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of words plus time-stamped idle tracking.
  logic [9:0] q[$];
  bit m_ovr = 0, m_tmo = 0;
  int m_pcnt = 0, m_fcnt = 0, cyc = 0, last_evt = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_ovr = 0; m_tmo = 0; m_pcnt = 0; m_fcnt = 0; last_evt = cyc;
    end else begin
      bit was_empty, was_full, acc_rd, acc_wr;
      was_empty = (q.size() == 0);
      was_full  = (q.size() == 16);
      acc_rd = rd_en && !was_empty;
      acc_wr = wr_tick && (!was_full || acc_rd);
      if (wr_tick && wr_data[9] && m_pcnt < 255) m_pcnt++;
      if (wr_tick && wr_data[8] && m_fcnt < 255) m_fcnt++;
      if (wr_tick && was_full && !rd_en) m_ovr = 1;
      if (acc_rd) void'(q.pop_front());
      if (acc_wr) q.push_back(wr_data);
      if (clr_status) begin m_ovr = 0; m_pcnt = 0; m_fcnt = 0; end
      cyc++;
      if (acc_rd || acc_wr || was_empty || timeout_cycles == 0) last_evt = cyc;
      if (clr_status || acc_rd || acc_wr) m_tmo = 0;
      else if (timeout_cycles != 0 && (cyc - last_evt) >= int'(timeout_cycles)) m_tmo = 1;
    end
  end

  always @(negedge clk) begin
    if (run && !reset) begin
      int n;
      n = q.size();
      chk("m_rd_data", 32'(rd_data), (n > 0) ? 32'(q[0]) : 32'd0);
      chk("m_empty", 32'(empty), 32'(n == 0));
      chk("m_full", 32'(full), 32'(n == 16));
      chk("m_level", 32'(level), 32'(n));
      chk("m_thresh_hit", 32'(thresh_hit), 32'(rx_thresh != 0 && n >= int'(rx_thresh)));
      chk("m_rx_timeout", 32'(rx_timeout), 32'(m_tmo));
      chk("m_overrun", 32'(overrun), 32'(m_ovr));
      chk("m_parity_cnt", 32'(parity_err_cnt), 32'(m_pcnt));
      chk("m_frame_cnt", 32'(frame_err_cnt), 32'(m_fcnt));
    end
  end

  // Inputs change 1 ns after the rising edge and are held until the next one.
  task automatic step(input bit w, input logic [9:0] d, input bit r, input bit c);
    wr_tick = w; wr_data = d; rd_en = r; clr_status = c;
    @(posedge clk); #1;
    wr_tick = 0; rd_en = 0; clr_status = 0;
  endtask

  task automatic wr(input logic [9:0] d); step(1, d, 0, 0); endtask
  task automatic pop(); step(0, '0, 1, 0); endtask
  task automatic idle(input int n); repeat (n) step(0, '0, 0, 0); endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] exp3[3];
    exp3[0] = 10'h041; exp3[1] = 10'h042; exp3[2] = 10'h043;
    #3 reset = 1'b1;
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    run = 1'b1;

    // FWFT ordering
    wr(10'h041);
    chk("t1_empty", 32'(empty), 32'd0);
    chk("t1_head", 32'(rd_data), 32'h041);
    idle(1); wr(10'h042); idle(1); wr(10'h043);
    chk("t1_level", 32'(level), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t1_pop", 32'(rd_data), 32'(exp3[i]));
      pop();
    end
    chk("t1_empty_end", 32'(empty), 32'd1);

    // Overflow drops the 17th word
    for (int i = 0; i < 17; i++) wr(10'(i));
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_level", 32'(level), 32'd16);
    chk("t2_overrun", 32'(overrun), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("t2_pop", 32'(rd_data), 32'(i));
      pop();
    end
    chk("t2_empty", 32'(empty), 32'd1);

    // Simultaneous read/write while full
    step(0, '0, 0, 1);
    for (int i = 0; i < 16; i++) wr(10'(8'h10 + i));
    step(1, 10'h0AA, 1, 0);
    chk("t3_level", 32'(level), 32'd16);
    chk("t3_overrun", 32'(overrun), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk("t3_pop", 32'(rd_data), (i == 15) ? 32'h0AA : 32'(8'h11 + i));
      pop();
    end

    // Error counters and clear
    wr(10'h255); wr(10'h155); wr(10'h355);
    chk("t4_parity", 32'(parity_err_cnt), 32'd2);
    chk("t4_frame", 32'(frame_err_cnt), 32'd2);
    step(0, '0, 0, 1);
    chk("t4_parity_clr", 32'(parity_err_cnt), 32'd0);
    chk("t4_frame_clr", 32'(frame_err_cnt), 32'd0);
    chk("t4_overrun_clr", 32'(overrun), 32'd0);
    repeat (3) pop();

    // Idle timeout
    timeout_cycles = 24'd100;
    wr(10'h07E);
    idle(99);
    chk("t5_before", 32'(rx_timeout), 32'd0);
    idle(1);
    chk("t5_at_100", 32'(rx_timeout), 32'd1);
    pop();
    chk("t5_pop_clr", 32'(rx_timeout), 32'd0);
    timeout_cycles = 24'd0;
    wr(10'h07F);
    idle(150);
    chk("t5_disabled", 32'(rx_timeout), 32'd0);
    pop();

    // Threshold and mid-operation reset
    rx_thresh = 5'd4;
    for (int i = 0; i < 3; i++) wr(10'(8'hA0 + i));
    chk("t6_below", 32'(thresh_hit), 32'd0);
    wr(10'h0A3);
    chk("t6_hit", 32'(thresh_hit), 32'd1);
    pop();
    chk("t6_fall", 32'(thresh_hit), 32'd0);
    wr(10'h0A4); wr(10'h0A5);
    chk("t6_level5", 32'(level), 32'd5);
    reset = 1'b1;
    #1;
    chk("t6_rst_empty", 32'(empty), 32'd1);
    chk("t6_rst_level", 32'(level), 32'd0);
    chk("t6_rst_thresh", 32'(thresh_hit), 32'd0);
    chk("t6_rst_rd_data", 32'(rd_data), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    idle(3);
    wr(10'h123);
    chk("t6_after_rst", 32'(rd_data), 32'h123);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer that sits directly downstream of the UART RX controller. It captures each received word (data plus the stop-error and parity-error flags) on the receiver's one-cycle done tick and stores it in a first-word-fall-through FIFO for the servo command logic to read. It also keeps overrun and line-error statistics, raises a fill-level threshold flag, and raises an idle-timeout flag so partial packets get serviced.

Parameters:
DATA_WIDTH, 10, width of the stored word: bit 9 parity error, bit 8 stop error, bits 7:0 data
ADDR_WIDTH, 4, FIFO depth = 2**ADDR_WIDTH (default 16 entries)
CNT_WIDTH, 8, width of the saturating error counters

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
wr_tick  in  1  one-cycle strobe from the UART receiver: word available
wr_data  in  DATA_WIDTH  received word; bit DATA_WIDTH-1 = parity error, bit DATA_WIDTH-2 = stop error
rd_en  in  1  pop the head entry
rd_data  out  DATA_WIDTH  head entry; valid while empty=0
empty  out  1  FIFO holds no entries
full  out  1  FIFO holds 2**ADDR_WIDTH entries
level  out  ADDR_WIDTH+1  current entry count
rx_thresh  in  ADDR_WIDTH+1  threshold level
thresh_hit  out  1  level >= rx_thresh, and rx_thresh != 0
timeout_cycles  in  24  idle timeout in clk cycles; 0 disables the timeout
rx_timeout  out  1  sticky idle-timeout flag
overrun  out  1  sticky flag: a write was dropped
parity_err_cnt  out  CNT_WIDTH  count of received words with the parity-error bit set
frame_err_cnt  out  CNT_WIDTH  count of received words with the stop-error bit set
clr_status  in  1  synchronous clear of overrun, both counters and rx_timeout

Behaviour:
- Reset values: rd_data=0, empty=1, full=0, level=0, thresh_hit=0, rx_timeout=0, overrun=0, both counters=0. Read and write pointers go to 0.
- Storage: register array indexed by ADDR_WIDTH-bit pointers that wrap modulo depth. level is tracked as a separate counter, or as the difference of (ADDR_WIDTH+1)-bit pointers.
- FWFT read: rd_data = mem[rd_ptr] combinationally whenever empty=0, and it is stable until popped. rd_en with empty=1 is ignored; pointers and level do not change.
- Write: wr_tick with full=0 stores wr_data at wr_ptr and increments wr_ptr. A word written in cycle N appears on rd_data and clears empty after the clk edge at the end of cycle N (1-cycle latency).
- wr_tick with full=1 and rd_en=0: the word is dropped, overrun is set to 1, and it stays 1 until clr_status or reset.
- wr_tick and rd_en in the same cycle:
  - empty=1: the write is performed and the read is ignored.
  - otherwise, including full=1: both are performed, level is unchanged, and no overrun is raised.
- Error counters: on every wr_tick, including dropped words, increment parity_err_cnt if wr_data[DATA_WIDTH-1]=1 and frame_err_cnt if wr_data[DATA_WIDTH-2]=1. Both counters saturate at all-ones.
- clr_status has priority over a simultaneous increment or overrun set in the same cycle; the affected flags and counters end the cycle at 0.
- thresh_hit is combinational from level and rx_thresh.
- Idle timer (24-bit):
  - Cleared to 0 when empty=1, on any accepted write, on any accepted read, or when timeout_cycles=0.
  - Otherwise increments each cycle.
  - When it reaches timeout_cycles, rx_timeout is set, and the timer holds.
  - rx_timeout clears on the next accepted read or write, or on clr_status.
- Reset asserted mid-operation: all stored contents are discarded (FIFO becomes empty) and all outputs return to their reset values immediately (asynchronous).

Test Plan:
- Reset, then write 0x041, 0x042, 0x043 on separated ticks -> after the first write edge, empty=0 and rd_data=0x041; level=3; three pops return 0x041, 0x042, 0x043 in order, then empty=1.
- Write 17 words into the depth-16 FIFO with rd_en=0 -> full=1, level=16, overrun=1; 16 pops return the first 16 words; the 17th word is never seen.
- With the FIFO full, assert wr_tick and rd_en in the same cycle -> level stays 16, overrun stays 0, and after 16 more pops the new word appears last.
- Write words 0x255, 0x155, 0x355 -> parity_err_cnt=2, frame_err_cnt=2; then pulse clr_status -> both counters=0 and overrun=0.
- timeout_cycles=100, write one word, then idle -> rx_timeout=1 exactly 100 cycles after the write edge; a pop clears it; with timeout_cycles=0 it never asserts.
- rx_thresh=4, write 4 words -> thresh_hit rises when level=4 and falls after one pop; asserting reset with level=5 gives empty=1, level=0 and thresh_hit=0 immediately.
